// File: rtl/snitch_tlb_refill_arbiter.sv
// rtl/snitch_tlb_refill_arbiter.sv - round-robin sharing of one L1 TLB refill port among NrPorts L0 TLBs
//
// Arbitrates L0 TLB miss requests round-robin. Each grant becomes one split
// request/response transaction on the L1 refill port. The PTE goes back to the
// granted L0 as a single-cycle ready pulse. An L1 fault is returned as an
// all-zero PTE, so the L0 raises the page fault on its next hit.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   flush_i           sfence; the in-flight response is discarded
//   l0_valid_i        per-port refill request, held until ready
//   l0_ready_o        one-hot pulse, PTE returned to that port this cycle
//   l0_va_i           per-port 20-bit VA to refill
//   l0_pte_o          PTE broadcast to all ports, valid where l0_ready_o is set
//   l0_is_4mega_o     4 MiB translation flag, broadcast
//   l1_req_valid_o    request to L1, with l1_req_ready_i and l1_req_va_o
//   l1_rsp_valid_i    L1 response (no backpressure), with l1_rsp_pte_i,
//                     l1_rsp_4mega_i and l1_rsp_fault_i
//
// All outputs come from registers. The ready pulse is registered in RESP, so it
// is visible in the cycle after RESP (that cycle is IDLE).
module snitch_tlb_refill_arbiter #(
    parameter int unsigned NrPorts = 2,
    parameter type l0_pte_t = logic
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic [NrPorts-1:0]       l0_valid_i,
    output logic [NrPorts-1:0]       l0_ready_o,
    input  logic [NrPorts-1:0][19:0] l0_va_i,
    output l0_pte_t                  l0_pte_o,
    output logic                     l0_is_4mega_o,
    output logic                     l1_req_valid_o,
    input  logic                     l1_req_ready_i,
    output logic [19:0]              l1_req_va_o,
    input  logic                     l1_rsp_valid_i,
    input  l0_pte_t                  l1_rsp_pte_i,
    input  logic                     l1_rsp_4mega_i,
    input  logic                     l1_rsp_fault_i
);

    localparam int unsigned IdxW = (NrPorts > 1) ? $clog2(NrPorts) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e            state;
    logic [IdxW-1:0]   rr_ptr;
    logic [IdxW-1:0]   gnt_idx;
    logic              drop;
    logic [NrPorts-1:0] ready_q;

    logic [NrPorts-1:0] arb_valid;
    logic               arb_found;
    logic [IdxW-1:0]    arb_idx;
    logic               hi_found;
    logic [IdxW-1:0]    hi_idx;
    logic [IdxW-1:0]    rr_next;

    l0_pte_t            rsp_pte;
    logic               rsp_4mega;

    // A served L0 keeps valid asserted during its ready pulse and one cycle
    // after it. Masking that port for those two cycles avoids a duplicate refill.
    assign arb_valid = l0_valid_i & ~(l0_ready_o | ready_q);

    // Round robin: lowest set bit at or above rr_ptr, else lowest set bit
    // overall (wrap). The descending loop leaves the lowest index in each.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        hi_found  = 1'b0;
        hi_idx    = '0;
        for (int p = int'(NrPorts) - 1; p >= 0; p--) begin
            if (arb_valid[p]) begin
                arb_found = 1'b1;
                arb_idx   = IdxW'(p);
                if (IdxW'(p) >= rr_ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = IdxW'(p);
                end
            end
        end
        if (hi_found) begin
            arb_idx = hi_idx;
        end
    end

    // With NrPorts=1 this always yields 0, so rr_ptr stays constant.
    assign rr_next = (arb_idx == IdxW'(NrPorts - 1)) ? '0 : arb_idx + IdxW'(1);

    // A faulting translation is handed back as an all-zero (not accessed) PTE.
    assign rsp_pte   = l1_rsp_fault_i ? '0 : l1_rsp_pte_i;
    assign rsp_4mega = l1_rsp_4mega_i & ~l1_rsp_fault_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= ST_IDLE;
            rr_ptr         <= '0;
            gnt_idx        <= '0;
            drop           <= 1'b0;
            ready_q        <= '0;
            l0_ready_o     <= '0;
            l0_pte_o       <= '0;
            l0_is_4mega_o  <= 1'b0;
            l1_req_valid_o <= 1'b0;
            l1_req_va_o    <= '0;
        end else begin
            l0_ready_o <= '0;
            ready_q    <= l0_ready_o;
            unique case (state)
                ST_IDLE: begin
                    drop <= 1'b0;
                    if (arb_found) begin
                        gnt_idx        <= arb_idx;
                        l1_req_va_o    <= l0_va_i[arb_idx];
                        rr_ptr         <= rr_next;
                        l1_req_valid_o <= 1'b1;
                        state          <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (flush_i) begin
                        drop <= 1'b1;
                    end
                    if (l1_req_ready_i) begin
                        l1_req_valid_o <= 1'b0;
                        // A response arriving with the accept skips WAIT.
                        if (l1_rsp_valid_i) begin
                            l0_pte_o      <= rsp_pte;
                            l0_is_4mega_o <= rsp_4mega;
                            state         <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (flush_i) begin
                        drop <= 1'b1;
                    end
                    if (l1_rsp_valid_i) begin
                        l0_pte_o      <= rsp_pte;
                        l0_is_4mega_o <= rsp_4mega;
                        state         <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // Flushed, or the requester withdrew: discard silently.
                    if (!drop && !flush_i && l0_valid_i[gnt_idx]) begin
                        l0_ready_o[gnt_idx] <= 1'b1;
                    end
                    drop  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Only one L1 transaction may be outstanding; a response is legal only
    // while waiting or together with the request accept.
    rsp_only_when_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
        l1_rsp_valid_i |-> ((state == ST_WAIT) || (state == ST_REQ && l1_req_ready_i)));

endmodule

// File: tb/tb_snitch_tlb_refill_arbiter.sv
// tb/tb_snitch_tlb_refill_arbiter.sv - directed self-checking bench for snitch_tlb_refill_arbiter
module tb_snitch_tlb_refill_arbiter;

    typedef logic [31:0] pte_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [1:0]       l0_valid;
    logic [1:0]       l0_ready;
    logic [1:0][19:0] l0_va;
    pte_t             l0_pte;
    logic             l0_is_4mega;
    logic             l1_req_valid;
    logic             l1_req_ready;
    logic [19:0]      l1_req_va;
    logic             l1_rsp_valid;
    pte_t             l1_rsp_pte;
    logic             l1_rsp_4mega;
    logic             l1_rsp_fault;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    snitch_tlb_refill_arbiter #(
        .NrPorts (2),
        .l0_pte_t(pte_t)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
        .l0_valid_i    (l0_valid),
        .l0_ready_o    (l0_ready),
        .l0_va_i       (l0_va),
        .l0_pte_o      (l0_pte),
        .l0_is_4mega_o (l0_is_4mega),
        .l1_req_valid_o(l1_req_valid),
        .l1_req_ready_i(l1_req_ready),
        .l1_req_va_o   (l1_req_va),
        .l1_rsp_valid_i(l1_rsp_valid),
        .l1_rsp_pte_i  (l1_rsp_pte),
        .l1_rsp_4mega_i(l1_rsp_4mega),
        .l1_rsp_fault_i(l1_rsp_fault)
    );

    // L0 requesters: tests raise issued[], the model raises done[].
    int          issued[2] = '{0, 0};
    int          done[2];
    int          hold[2];
    logic [19:0] va_cfg[2] = '{20'h0, 20'h0};

    assign l0_valid = {(issued[1] != done[1]), (issued[0] != done[0])};
    assign l0_va    = {va_cfg[1], va_cfg[0]};

    // L1 model configuration, written by tests only.
    int   cfg_rdy_delay = 0;
    int   cfg_rsp_lat = 0;
    pte_t cfg_pte = '0;
    int   cfg_step = 0;
    logic cfg_4mega = 1'b0;
    logic cfg_fault = 1'b0;

    int m_state;
    int m_cnt;
    int n_rsp;

    task automatic drive_rsp();
        l1_rsp_valid = 1'b1;
        l1_rsp_pte   = cfg_pte + pte_t'(cfg_step * n_rsp);
        l1_rsp_4mega = cfg_4mega;
        l1_rsp_fault = cfg_fault;
        n_rsp        = n_rsp + 1;
    endtask

    // L0 and L1 behavioural models, evaluated 2 time units after each edge.
    initial begin
        m_state = 0; m_cnt = 0; n_rsp = 0;
        done = '{0, 0}; hold = '{0, 0};
        l1_req_ready = 1'b0; l1_rsp_valid = 1'b0; l1_rsp_pte = '0;
        l1_rsp_4mega = 1'b0; l1_rsp_fault = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            l1_req_ready = 1'b0;
            l1_rsp_valid = 1'b0;
            if (rst) begin
                m_state = 0;
                n_rsp   = 0;
                for (int p = 0; p < 2; p++) begin
                    done[p] = issued[p];
                    hold[p] = 0;
                end
            end else begin
                // An L0 keeps valid for its ready cycle and one more cycle.
                for (int p = 0; p < 2; p++) begin
                    if (hold[p] == 1) begin
                        hold[p] = 0;
                        done[p] = done[p] + 1;
                    end else if (hold[p] > 1) begin
                        hold[p] = hold[p] - 1;
                    end
                    if (l0_ready[p]) hold[p] = 2;
                end
                if (m_state == 0 && l1_req_valid) begin
                    m_state = 1;
                    m_cnt   = 0;
                end
                if (m_state == 1) begin
                    if (m_cnt >= cfg_rdy_delay) begin
                        l1_req_ready = 1'b1;
                        m_cnt   = 0;
                        m_state = 2;
                        if (cfg_rsp_lat == 0) begin
                            drive_rsp();
                            m_state = 0;
                        end
                    end else begin
                        m_cnt = m_cnt + 1;
                    end
                end else if (m_state == 2) begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt >= cfg_rsp_lat) begin
                        drive_rsp();
                        m_state = 0;
                    end
                end
            end
        end
    end

    // Monitor: log ready pulses and L1 request handshakes.
    int          cyc = 0;
    logic [1:0]  pq_rdy[$];
    pte_t        pq_pte[$];
    logic        pq_4m[$];
    int          pq_cyc[$];
    logic [19:0] hq_va[$];
    int          hq_cyc[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (l0_ready != 2'b00) begin
            pq_rdy.push_back(l0_ready);
            pq_pte.push_back(l0_pte);
            pq_4m.push_back(l0_is_4mega);
            pq_cyc.push_back(cyc);
        end
        if (l1_req_valid && l1_req_ready) begin
            hq_va.push_back(l1_req_va);
            hq_cyc.push_back(cyc);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic wait_pulses(input int n, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            if (pq_rdy.size() >= n) ok = 1'b1;
            else step(1);
        end
    endtask

    task automatic wait_req(input logic want, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            if (l1_req_valid === want) ok = 1'b1;
            else step(1);
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({l0_ready, l1_req_valid, l0_is_4mega} !== 4'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b want 0000", {l0_ready, l1_req_valid, l0_is_4mega});
        end
        tests_run++;
        if (l0_pte !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_pte: got %h want 00000000", l0_pte);
        end
    endtask

    task automatic test_single();
        int pb, hb;
        bit ok;
        do_reset();
        cfg_rdy_delay = 3; cfg_rsp_lat = 0; cfg_pte = 32'hCAFE00CF;
        cfg_step = 0; cfg_4mega = 1'b0; cfg_fault = 1'b0;
        pb = pq_rdy.size(); hb = hq_va.size();
        va_cfg[0] = 20'h12345;
        issued[0] = issued[0] + 1;
        wait_pulses(pb + 1, 60, ok);
        step(8);
        tests_run++;
        if (ok !== 1'b1) begin tests_failed++; $display("FAIL single_timeout: got no ready pulse want one"); end
        tests_run++;
        if (hq_va.size() - hb !== 1) begin
            tests_failed++; $display("FAIL single_req_count: got %0d want 1", hq_va.size() - hb);
        end else begin
            tests_run++;
            if (hq_va[hb] !== 20'h12345) begin tests_failed++; $display("FAIL single_req_va: got %h want 12345", hq_va[hb]); end
        end
        tests_run++;
        if (pq_rdy.size() - pb !== 1) begin
            tests_failed++; $display("FAIL single_pulse_count: got %0d want 1", pq_rdy.size() - pb);
        end else begin
            tests_run++;
            if ({pq_rdy[pb], pq_4m[pb], pq_pte[pb]} !== {2'b01, 1'b0, 32'hCAFE00CF}) begin
                tests_failed++;
                $display("FAIL single_pulse: got rdy=%b 4m=%b pte=%h want rdy=01 4m=0 pte=cafe00cf", pq_rdy[pb], pq_4m[pb], pq_pte[pb]);
            end
            if (hq_va.size() > hb) begin
                tests_run++;
                if (pq_cyc[pb] - hq_cyc[hb] !== 2) begin
                    tests_failed++; $display("FAIL single_latency: got %0d want 2", pq_cyc[pb] - hq_cyc[hb]);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        int pb, hb;
        bit ok;
        do_reset();
        cfg_rdy_delay = 0; cfg_rsp_lat = 1; cfg_pte = 32'h11110000;
        cfg_step = 1; cfg_4mega = 1'b1; cfg_fault = 1'b0;
        pb = pq_rdy.size(); hb = hq_va.size();
        va_cfg[0] = 20'h00001; va_cfg[1] = 20'h00002;
        issued[0] = issued[0] + 1; issued[1] = issued[1] + 1;
        wait_pulses(pb + 2, 80, ok);
        step(6);
        tests_run++;
        if (ok !== 1'b1 || pq_rdy.size() - pb !== 2 || hq_va.size() - hb !== 2) begin
            tests_failed++;
            $display("FAIL simul_counts: got pulses=%0d reqs=%0d want 2 2", pq_rdy.size() - pb, hq_va.size() - hb);
        end else begin
            tests_run++;
            if ({hq_va[hb], hq_va[hb+1]} !== {20'h00001, 20'h00002}) begin
                tests_failed++; $display("FAIL simul_req_order: got %h %h want 00001 00002", hq_va[hb], hq_va[hb+1]);
            end
            tests_run++;
            if ({pq_rdy[pb], pq_rdy[pb+1]} !== 4'b0110) begin
                tests_failed++; $display("FAIL simul_pulse_order: got %b %b want 01 10", pq_rdy[pb], pq_rdy[pb+1]);
            end
            tests_run++;
            if ({pq_pte[pb], pq_4m[pb], pq_pte[pb+1], pq_4m[pb+1]} !== {32'h11110000, 1'b1, 32'h11110001, 1'b1}) begin
                tests_failed++;
                $display("FAIL simul_pte: got %h/%b %h/%b want 11110000/1 11110001/1", pq_pte[pb], pq_4m[pb], pq_pte[pb+1], pq_4m[pb+1]);
            end
        end
        // rr_ptr must have wrapped to 0: port 0 wins the next tie.
        hb = hq_va.size();
        issued[0] = issued[0] + 1; issued[1] = issued[1] + 1;
        wait_pulses(pq_rdy.size() + 1, 80, ok);
        tests_run++;
        if (hq_va.size() <= hb) begin
            tests_failed++; $display("FAIL simul_rr_wrap: got no request want va 00001");
        end else if (hq_va[hb] !== 20'h00001) begin
            tests_failed++; $display("FAIL simul_rr_wrap: got %h want 00001", hq_va[hb]);
        end
    endtask

    task automatic test_fairness();
        int pb;
        bit ok;
        logic [1:0] want;
        do_reset();
        cfg_rdy_delay = 1; cfg_rsp_lat = 2; cfg_pte = 32'h0; cfg_step = 0;
        cfg_4mega = 1'b0; cfg_fault = 1'b0;
        pb = pq_rdy.size();
        va_cfg[0] = 20'h000A0; va_cfg[1] = 20'h000B1;
        issued[1] = issued[1] + 100;
        issued[0] = issued[0] + 3;
        wait_pulses(pb + 8, 300, ok);
        tests_run++;
        if (ok !== 1'b1) begin
            tests_failed++; $display("FAIL fair_timeout: got %0d pulses want 8", pq_rdy.size() - pb);
        end else begin
            for (int i = 0; i < 8; i++) begin
                want = (i < 6 && (i % 2) == 0) ? 2'b01 : 2'b10;
                tests_run++;
                if (pq_rdy[pb+i] !== want) begin
                    tests_failed++; $display("FAIL fair_grant_%0d: got %b want %b", i, pq_rdy[pb+i], want);
                end
            end
        end
    endtask

    task automatic test_flush();
        int pb, hb;
        bit ok1, ok2, ok3;
        do_reset();
        cfg_rdy_delay = 0; cfg_rsp_lat = 4; cfg_pte = 32'h00001000; cfg_step = 1;
        cfg_4mega = 1'b0; cfg_fault = 1'b0;
        pb = pq_rdy.size(); hb = hq_va.size();
        va_cfg[0] = 20'h0C0DE;
        issued[0] = issued[0] + 1;
        wait_req(1'b1, 20, ok1);
        step(1);
        wait_req(1'b0, 20, ok2);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        wait_pulses(pb + 1, 80, ok3);
        step(6);
        tests_run++;
        if ({ok1, ok2, ok3} !== 3'b111) begin
            tests_failed++; $display("FAIL flush_timeout: got %b want 111", {ok1, ok2, ok3});
        end
        tests_run++;
        if (hq_va.size() - hb !== 2) begin
            tests_failed++; $display("FAIL flush_req_count: got %0d want 2", hq_va.size() - hb);
        end else if ({hq_va[hb], hq_va[hb+1]} !== {20'h0C0DE, 20'h0C0DE}) begin
            tests_failed++; $display("FAIL flush_req_va: got %h %h want 0c0de 0c0de", hq_va[hb], hq_va[hb+1]);
        end
        tests_run++;
        if (pq_rdy.size() - pb !== 1) begin
            tests_failed++; $display("FAIL flush_pulse_count: got %0d want 1", pq_rdy.size() - pb);
        end else if ({pq_rdy[pb], pq_pte[pb]} !== {2'b01, 32'h00001001}) begin
            tests_failed++; $display("FAIL flush_pulse: got %b %h want 01 00001001", pq_rdy[pb], pq_pte[pb]);
        end
    endtask

    task automatic test_fault();
        int pb;
        bit ok;
        do_reset();
        cfg_rdy_delay = 0; cfg_rsp_lat = 1; cfg_pte = 32'h00ABC0CF; cfg_step = 0;
        cfg_4mega = 1'b1; cfg_fault = 1'b0;
        pb = pq_rdy.size();
        va_cfg[1] = 20'h00400;
        issued[1] = issued[1] + 1;
        wait_pulses(pb + 1, 60, ok);
        step(4);
        tests_run++;
        if (pq_rdy.size() - pb !== 1) begin
            tests_failed++; $display("FAIL mega_pulse_count: got %0d want 1", pq_rdy.size() - pb);
        end else if ({pq_rdy[pb], pq_4m[pb], pq_pte[pb]} !== {2'b10, 1'b1, 32'h00ABC0CF}) begin
            tests_failed++;
            $display("FAIL mega_pulse: got %b %b %h want 10 1 00abc0cf", pq_rdy[pb], pq_4m[pb], pq_pte[pb]);
        end
        cfg_pte = 32'hFFFFFFFF; cfg_fault = 1'b1;
        pb = pq_rdy.size();
        va_cfg[0] = 20'h00BAD;
        issued[0] = issued[0] + 1;
        wait_pulses(pb + 1, 60, ok);
        step(4);
        tests_run++;
        if (pq_rdy.size() - pb !== 1) begin
            tests_failed++; $display("FAIL fault_pulse_count: got %0d want 1", pq_rdy.size() - pb);
        end else if ({pq_rdy[pb], pq_4m[pb], pq_pte[pb]} !== {2'b01, 1'b0, 32'h0}) begin
            tests_failed++;
            $display("FAIL fault_pulse: got %b %b %h want 01 0 00000000", pq_rdy[pb], pq_4m[pb], pq_pte[pb]);
        end
    endtask

    task automatic test_stall_reset();
        int pb;
        bit ok;
        do_reset();
        cfg_rdy_delay = 1000; cfg_rsp_lat = 0; cfg_pte = 32'h0; cfg_step = 0;
        cfg_4mega = 1'b0; cfg_fault = 1'b0;
        pb = pq_rdy.size();
        va_cfg[0] = 20'h7777F;
        issued[0] = issued[0] + 1;
        wait_req(1'b1, 20, ok);
        tests_run++;
        if (ok !== 1'b1) begin tests_failed++; $display("FAIL stall_no_req: got no request want one"); end
        for (int i = 0; i < 10; i++) begin
            step(1);
            tests_run++;
            if ({l1_req_valid, l1_req_va, l0_ready} !== {1'b1, 20'h7777F, 2'b00}) begin
                tests_failed++;
                $display("FAIL stall_cycle_%0d: got v=%b va=%h rdy=%b want 1 7777f 00", i, l1_req_valid, l1_req_va, l0_ready);
            end
        end
        rst = 1'b1;
        step(1);
        tests_run++;
        if ({l0_ready, l1_req_valid, l1_req_va, l0_pte, l0_is_4mega} !== 56'h0) begin
            tests_failed++;
            $display("FAIL stall_reset: got rdy=%b v=%b va=%h pte=%h 4m=%b want all 0", l0_ready, l1_req_valid, l1_req_va, l0_pte, l0_is_4mega);
        end
        rst = 1'b0;
        step(6);
        tests_run++;
        if (pq_rdy.size() !== pb) begin
            tests_failed++; $display("FAIL stall_no_pulse: got %0d pulses want 0", pq_rdy.size() - pb);
        end
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_flush();
        test_fault();
        test_stall_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
